// File: rtl/transposer_core.sv
// Transposer core: a strided read-address generator feeds a byte-shuffling datapath, and a
// second strided generator places each transformed word. One transfer per init_pulse.
module transposer_core #(
  parameter int unsigned AW    = 16,
  parameter int unsigned BUFFD = 64,
  parameter int unsigned ADIM  = 6
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               init_pulse,
  input  logic               repack_en,
  input  logic [1:0]         mode,
  input  logic [AW-1:0]      rreq_num,
  input  logic [AW-1:0]      raddr_base,
  input  logic [AW-1:0]      raddr_size   [ADIM],
  input  logic [AW-1:0]      raddr_stride [ADIM],
  input  logic [AW-1:0]      wreq_num,
  input  logic [AW-1:0]      waddr_base,
  input  logic [AW-1:0]      waddr_size   [ADIM],
  input  logic [AW-1:0]      waddr_stride [ADIM],
  input  logic [AW-1:0]      packed_dim_size,
  input  logic [AW-1:0]      unpacked_dim_size,
  output logic [AW-1:0]      raddr,
  output logic               raddr_vld,
  input  logic [BUFFD*8-1:0] rdata,
  input  logic               rdata_vld,
  output logic [AW-1:0]      waddr,
  output logic [BUFFD*8-1:0] wdata,
  output logic               wdata_vld,
  output logic               finish
);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e             state_q;
  logic               repack_q;
  logic [1:0]         mode_q;
  logic [AW-1:0]      rnum_q, rbase_q, wnum_q, wbase_q, p_q, u_q;
  logic [AW-1:0]      rsize_q [ADIM];
  logic [AW-1:0]      rstride_q [ADIM];
  logic [AW-1:0]      wsize_q [ADIM];
  logic [AW-1:0]      wstride_q [ADIM];
  logic [AW-1:0]      ridx_q [ADIM];
  logic [AW-1:0]      widx_q [ADIM];
  logic [AW-1:0]      rcnt_q, wcnt_q;
  logic [AW-1:0]      raddr_q, waddr_q;
  logic               raddr_vld_q, wdata_vld_q, finish_q;
  logic [BUFFD*8-1:0] wdata_q;

  // Read side sees the live config in the init cycle so the first address leaves one cycle later
  logic [AW-1:0] rd_base, rd_num, rd_cnt, rd_addr;
  logic [AW-1:0] rd_size [ADIM];
  logic [AW-1:0] rd_stride [ADIM];
  logic [AW-1:0] rd_idx [ADIM];
  logic [AW-1:0] rd_next [ADIM];
  logic          rd_go;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] wr_next [ADIM];
  logic [BUFFD*8-1:0] xform_data;

  assign raddr     = raddr_q;
  assign raddr_vld = raddr_vld_q;
  assign waddr     = waddr_q;
  assign wdata     = wdata_q;
  assign wdata_vld = wdata_vld_q;
  assign finish    = finish_q;

  // Read generator: current address and mixed-radix increment of the index vector
  always_comb begin
    logic carry;
    carry   = 1'b1;
    rd_base = init_pulse ? raddr_base : rbase_q;
    rd_num  = init_pulse ? rreq_num : rnum_q;
    rd_cnt  = init_pulse ? '0 : rcnt_q;
    rd_addr = rd_base;
    for (int unsigned d = 0; d < ADIM; d++) begin
      rd_size[d]   = init_pulse ? raddr_size[d] : rsize_q[d];
      rd_stride[d] = init_pulse ? raddr_stride[d] : rstride_q[d];
      rd_idx[d]    = init_pulse ? '0 : ridx_q[d];
      rd_addr      = rd_addr + rd_idx[d] * rd_stride[d];
      rd_next[d]   = rd_idx[d];
      if (carry) begin
        // size 0 behaves as 1; the outermost carry-out is simply dropped
        if (rd_size[d] <= AW'(1) || rd_idx[d] >= rd_size[d] - AW'(1)) begin
          rd_next[d] = '0;
        end else begin
          rd_next[d] = rd_idx[d] + AW'(1);
          carry      = 1'b0;
        end
      end
    end
    rd_go = (init_pulse ? (wreq_num != '0) : (state_q == StBusy)) && (rd_cnt < rd_num);
  end

  // Write generator: same addressing rule over the captured write config
  always_comb begin
    logic carry;
    carry   = 1'b1;
    wr_addr = wbase_q;
    for (int unsigned d = 0; d < ADIM; d++) begin
      wr_addr    = wr_addr + widx_q[d] * wstride_q[d];
      wr_next[d] = widx_q[d];
      if (carry) begin
        if (wsize_q[d] <= AW'(1) || widx_q[d] >= wsize_q[d] - AW'(1)) begin
          wr_next[d] = '0;
        end else begin
          wr_next[d] = widx_q[d] + AW'(1);
          carry      = 1'b0;
        end
      end
    end
  end

  // Data transform: bypass, P x U tile transpose, or full byte reversal
  always_comb begin
    logic [31:0] pu;
    logic        tvalid;
    pu         = 32'(p_q) * 32'(u_q);
    tvalid     = (p_q != '0) && (u_q != '0) && (pu <= 32'(BUFFD));
    xform_data = rdata;
    case (mode_q)
      2'b01: begin
        if (tvalid) begin
          for (int unsigned k = 0; k < BUFFD; k++) begin
            if (repack_q && k >= pu) xform_data[k*8 +: 8] = 8'h00;
          end
          for (int unsigned i = 0; i < BUFFD; i++) begin
            for (int unsigned j = 0; j < BUFFD; j++) begin
              if (i < 32'(u_q) && j < 32'(p_q)) begin
                xform_data[(j*32'(u_q)+i)*8 +: 8] = rdata[(i*32'(p_q)+j)*8 +: 8];
              end
            end
          end
        end
      end
      2'b10: begin
        for (int unsigned k = 0; k < BUFFD; k++) begin
          xform_data[k*8 +: 8] = rdata[(BUFFD-1-k)*8 +: 8];
        end
      end
      default: ;
    endcase
  end

  // Control FSM, config capture, counters and all registered outputs
  always_ff @(posedge clk or posedge reset_n) begin
    if (reset_n) begin
      state_q     <= StIdle;
      repack_q    <= 1'b0;
      mode_q      <= 2'b00;
      rnum_q      <= '0;
      rbase_q     <= '0;
      wnum_q      <= '0;
      wbase_q     <= '0;
      p_q         <= '0;
      u_q         <= '0;
      rcnt_q      <= '0;
      wcnt_q      <= '0;
      raddr_q     <= '0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      raddr_vld_q <= 1'b0;
      wdata_vld_q <= 1'b0;
      finish_q    <= 1'b0;
      for (int unsigned d = 0; d < ADIM; d++) begin
        rsize_q[d]   <= '0;
        rstride_q[d] <= '0;
        wsize_q[d]   <= '0;
        wstride_q[d] <= '0;
        ridx_q[d]    <= '0;
        widx_q[d]    <= '0;
      end
    end else begin
      raddr_vld_q <= 1'b0;
      wdata_vld_q <= 1'b0;
      finish_q    <= 1'b0;

      if (init_pulse) begin
        repack_q <= repack_en;
        mode_q   <= mode;
        rnum_q   <= rreq_num;
        rbase_q  <= raddr_base;
        wnum_q   <= wreq_num;
        wbase_q  <= waddr_base;
        p_q      <= packed_dim_size;
        u_q      <= unpacked_dim_size;
        wcnt_q   <= '0;
        for (int unsigned d = 0; d < ADIM; d++) begin
          rsize_q[d]   <= raddr_size[d];
          rstride_q[d] <= raddr_stride[d];
          wsize_q[d]   <= waddr_size[d];
          wstride_q[d] <= waddr_stride[d];
          widx_q[d]    <= '0;
        end
        // An empty write job completes immediately
        state_q  <= (wreq_num == '0) ? StIdle : StBusy;
        finish_q <= (wreq_num == '0);
      end

      if (rd_go) begin
        raddr_q     <= rd_addr;
        raddr_vld_q <= 1'b1;
        rcnt_q      <= rd_cnt + AW'(1);
        ridx_q      <= rd_next;
      end else if (init_pulse) begin
        rcnt_q <= '0;
        for (int unsigned d = 0; d < ADIM; d++) ridx_q[d] <= '0;
      end

      if (!init_pulse && state_q == StBusy) begin
        if (wcnt_q == wnum_q) begin
          state_q  <= StIdle;
          finish_q <= 1'b1;
        end else if (rdata_vld) begin
          wdata_q     <= xform_data;
          waddr_q     <= wr_addr;
          wdata_vld_q <= 1'b1;
          wcnt_q      <= wcnt_q + AW'(1);
          widx_q      <= wr_next;
        end
      end
    end
  end

endmodule

// File: tb/tb_transposer_core.sv
// Bench for transposer_core: directed and randomized transfers checked against a
// mixed-radix address model and a per-output-byte transform model.
module tb_transposer_core;
  localparam int AW    = 16;
  localparam int BUFFD = 64;
  localparam int ADIM  = 6;
  localparam int DW    = BUFFD * 8;

  typedef logic [AW-1:0] vec_t [ADIM];

  logic          clk = 1'b0;
  logic          reset_n, init_pulse, repack_en, rdata_vld;
  logic [1:0]    mode;
  logic [AW-1:0] rreq_num, raddr_base, wreq_num, waddr_base, packed_dim_size, unpacked_dim_size;
  vec_t          raddr_size, raddr_stride, waddr_size, waddr_stride;
  logic [DW-1:0] rdata, wdata;
  logic [AW-1:0] raddr, waddr;
  logic          raddr_vld, wdata_vld, finish;

  always #5 clk = ~clk;

  transposer_core #(.AW(AW), .BUFFD(BUFFD), .ADIM(ADIM)) dut (
    .clk(clk), .reset_n(reset_n), .init_pulse(init_pulse), .repack_en(repack_en), .mode(mode),
    .rreq_num(rreq_num), .raddr_base(raddr_base), .raddr_size(raddr_size),
    .raddr_stride(raddr_stride), .wreq_num(wreq_num), .waddr_base(waddr_base),
    .waddr_size(waddr_size), .waddr_stride(waddr_stride), .packed_dim_size(packed_dim_size),
    .unpacked_dim_size(unpacked_dim_size), .raddr(raddr), .raddr_vld(raddr_vld),
    .rdata(rdata), .rdata_vld(rdata_vld), .waddr(waddr), .wdata(wdata),
    .wdata_vld(wdata_vld), .finish(finish)
  );

  int tests = 0;
  int fails = 0;

  // Configuration the model believes is in force
  vec_t          c_rsize, c_rstride, c_wsize, c_wstride;
  logic [AW-1:0] c_rbase, c_wbase, c_rnum, c_wnum, c_p, c_u;
  logic [1:0]    c_mode;
  logic          c_repack;
  logic [DW-1:0] first_wdata;
  int            n_wvld, n_fin;

  task automatic chk_vec(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // n-th address of a mixed-radix walk, innermost dimension first
  function automatic logic [AW-1:0] model_addr(input logic [AW-1:0] base, input vec_t sz,
                                               input vec_t st, input int n);
    int unsigned   rem;
    int unsigned   s;
    logic [AW-1:0] acc;
    rem = n;
    acc = base;
    for (int d = 0; d < ADIM; d++) begin
      s   = (sz[d] == '0) ? 1 : 32'(sz[d]);
      acc = acc + 16'((rem % s) * 32'(st[d]));
      rem = rem / s;
    end
    return acc;
  endfunction

  function automatic logic [DW-1:0] model_xform(input logic [DW-1:0] din);
    logic [DW-1:0] o;
    int unsigned   pu, p, u;
    o  = din;
    p  = 32'(c_p);
    u  = 32'(c_u);
    pu = p * u;
    case (c_mode)
      2'd1: begin
        if (p != 0 && u != 0 && pu <= BUFFD) begin
          if (c_repack) for (int unsigned q = pu; q < BUFFD; q++) o[q*8 +: 8] = 8'h00;
          // output byte q sits at column j = q/U, row i = q%U of the transposed tile
          for (int unsigned q = 0; q < pu; q++) o[q*8 +: 8] = din[((q % u) * p + q / u)*8 +: 8];
        end
      end
      2'd2: for (int k = 0; k < BUFFD; k++) o[k*8 +: 8] = din[(BUFFD-1-k)*8 +: 8];
      default: ;
    endcase
    return o;
  endfunction

  task automatic scramble_cfg();
    repack_en         = 1'($urandom());
    mode              = 2'($urandom());
    rreq_num          = 16'($urandom());
    raddr_base        = 16'($urandom());
    wreq_num          = 16'($urandom());
    waddr_base        = 16'($urandom());
    packed_dim_size   = 16'($urandom());
    unpacked_dim_size = 16'($urandom());
    for (int d = 0; d < ADIM; d++) begin
      raddr_size[d]   = 16'($urandom());
      raddr_stride[d] = 16'($urandom());
      waddr_size[d]   = 16'($urandom());
      waddr_stride[d] = 16'($urandom());
    end
  endtask

  // Start a job from c_* and run ncyc cycles; rdata returns lat cycles after each read
  task automatic run(input int ncyc, input int lat, input bit count_pat);
    logic [DW-1:0] pend_data, d;
    bit            pend, exp_w;
    int            wdone, fin_edge;
    wdone = 0; pend = 1'b0; pend_data = '0; n_wvld = 0; n_fin = 0; first_wdata = '0;
    fin_edge = (c_wnum == '0) ? 0 : -1;
    repack_en = c_repack; mode = c_mode; rreq_num = c_rnum; raddr_base = c_rbase;
    wreq_num = c_wnum; waddr_base = c_wbase; packed_dim_size = c_p; unpacked_dim_size = c_u;
    raddr_size = c_rsize; raddr_stride = c_rstride; waddr_size = c_wsize;
    waddr_stride = c_wstride;
    init_pulse = 1'b1;
    rdata_vld  = 1'b0;
    @(posedge clk); #1;
    init_pulse = 1'b0;
    scramble_cfg();
    for (int e = 0; e < ncyc; e++) begin
      chk_bit("raddr_vld", raddr_vld, 1'(e < int'(c_rnum)));
      if (e < int'(c_rnum))
        chk_vec("raddr", DW'(raddr), DW'(model_addr(c_rbase, c_rsize, c_rstride, e)));
      exp_w = pend && (wdone < int'(c_wnum));
      chk_bit("wdata_vld", wdata_vld, exp_w);
      if (wdata_vld) n_wvld++;
      if (finish) n_fin++;
      if (exp_w) begin
        chk_vec("waddr", DW'(waddr), DW'(model_addr(c_wbase, c_wsize, c_wstride, wdone)));
        chk_vec("wdata", wdata, model_xform(pend_data));
        if (wdone == 0) first_wdata = wdata;
        wdone++;
        if (wdone == int'(c_wnum)) fin_edge = e + 1;
      end
      chk_bit("finish", finish, 1'(e == fin_edge));
      pend = (e + 1 >= lat) && (e + 1 - lat < int'(c_rnum));
      for (int k = 0; k < BUFFD / 4; k++) d[k*32 +: 32] = $urandom();
      if (count_pat) for (int k = 0; k < BUFFD; k++) d[k*8 +: 8] = 8'(k);
      pend_data = d;
      rdata     = d;
      rdata_vld = pend;
      @(posedge clk); #1;
    end
    rdata_vld = 1'b0;
  endtask

  task automatic default_cfg();
    c_rsize = '{default: 16'd1}; c_rstride = '{default: 16'd0};
    c_wsize = '{default: 16'd1}; c_wstride = '{default: 16'd0};
    c_wsize[0] = 16'd8; c_wstride[0] = 16'd1;
    c_rbase = '0; c_wbase = 16'h4000; c_rnum = '0; c_wnum = '0;
    c_p = '0; c_u = '0; c_mode = 2'd0; c_repack = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] exp21;
    reset_n = 1'b1; init_pulse = 1'b0; rdata_vld = 1'b0; rdata = '0;
    scramble_cfg();
    repeat (2) @(posedge clk);
    #1;
    chk_vec("rst_raddr", DW'(raddr), '0);
    chk_bit("rst_raddr_vld", raddr_vld, 1'b0);
    chk_vec("rst_waddr", DW'(waddr), '0);
    chk_vec("rst_wdata", wdata, '0);
    chk_bit("rst_wdata_vld", wdata_vld, 1'b0);
    chk_bit("rst_finish", finish, 1'b0);
    reset_n = 1'b0;
    @(posedge clk); #1;

    // Linear read walk from 0x100
    default_cfg();
    c_rbase = 16'h0100; c_rsize[0] = 16'd4; c_rstride[0] = 16'd1;
    c_rnum = 16'd4; c_wnum = 16'd4;
    run(10, 2, 1'b0);

    // 2-D read wrap with byte reversal and a 2-D write pattern
    default_cfg();
    c_rsize[0] = 16'd2; c_rsize[1] = 16'd3; c_rstride[0] = 16'd4; c_rstride[1] = 16'd16;
    c_wbase = 16'h0200; c_wsize[0] = 16'd3; c_wsize[1] = 16'd0; c_wsize[2] = 16'd2;
    c_wstride[0] = 16'd2; c_wstride[1] = 16'd7; c_wstride[2] = 16'h0100;
    c_rnum = 16'd6; c_wnum = 16'd6; c_mode = 2'd2;
    run(14, 3, 1'b1);
    chk_vec("rev_byte0", DW'(first_wdata[7:0]), DW'(8'h3f));
    chk_vec("rev_byte63", DW'(first_wdata[DW-1 -: 8]), '0);

    // 4x2 tile transpose with repack
    default_cfg();
    c_mode = 2'd1; c_p = 16'd4; c_u = 16'd2; c_repack = 1'b1; c_rnum = 16'd2; c_wnum = 16'd2;
    run(6, 1, 1'b1);
    exp21 = '0;
    exp21[63:0] = 64'h0703_0602_0501_0400;
    chk_vec("tile_4x2", first_wdata, exp21);

    // Leave a job unfinished; the next init_pulse must restart cleanly
    default_cfg();
    c_rnum = 16'd8; c_wnum = 16'd8; c_mode = 2'd2;
    run(3, 2, 1'b0);

    // Extra beat after the write budget is used up
    default_cfg();
    c_rnum = 16'd3; c_wnum = 16'd2; c_mode = 2'd1; c_p = 16'd3; c_u = 16'd5;
    run(8, 1, 1'b0);
    chk_vec("wvld_count", DW'(n_wvld), DW'(2));
    chk_vec("finish_count", DW'(n_fin), DW'(1));

    // Empty job: immediate finish, no reads
    default_cfg();
    run(4, 1, 1'b0);

    // Randomized jobs
    for (int t = 0; t < 8; t++) begin
      default_cfg();
      for (int d = 0; d < ADIM; d++) begin
        c_rsize[d] = 16'($urandom_range(0, 3)); c_rstride[d] = 16'($urandom());
        c_wsize[d] = 16'($urandom_range(0, 3)); c_wstride[d] = 16'($urandom());
      end
      c_rbase = 16'($urandom()); c_wbase = 16'($urandom());
      c_mode = 2'($urandom()); c_repack = 1'($urandom());
      c_p = 16'($urandom_range(0, 10)); c_u = 16'($urandom_range(0, 10));
      c_rnum = 16'($urandom_range(1, 12));
      c_wnum = (c_rnum > 16'd1 && $urandom_range(0, 1) == 1) ? c_rnum - 16'd1 : c_rnum;
      run(int'(c_rnum) + 10, int'($urandom_range(1, 4)), 1'b0);
    end

    // Reset mid-transfer aborts without finish and stays idle
    default_cfg();
    c_rnum = 16'd8; c_wnum = 16'd8;
    run(3, 1, 1'b0);
    rdata_vld = 1'b1;
    reset_n = 1'b1;
    #1;
    chk_vec("abort_raddr", DW'(raddr), '0);
    chk_bit("abort_raddr_vld", raddr_vld, 1'b0);
    chk_vec("abort_waddr", DW'(waddr), '0);
    chk_vec("abort_wdata", wdata, '0);
    chk_bit("abort_wdata_vld", wdata_vld, 1'b0);
    chk_bit("abort_finish", finish, 1'b0);
    @(posedge clk); #1;
    reset_n = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk_bit("idle_raddr_vld", raddr_vld, 1'b0);
      chk_bit("idle_wdata_vld", wdata_vld, 1'b0);
      chk_bit("idle_finish", finish, 1'b0);
    end
    rdata_vld = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/transposer_core.md
TRANSPOSER_CORE -- requirements
Module: transposer_core

Interface
REQ-001 SHALL have parameters: AW 16, address/count width; BUFFD 64, bytes per data word; ADIM 6, number of address dimensions.
REQ-002 SHALL have ports, clock and reset first:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-high reset.
- init_pulse  in  1  start; latches all configuration.
- repack_en  in  1  zero-pad bytes outside the transposed tile.
- mode  in  2  data transform select.
- rreq_num, raddr_base  in  AW  read count and read base address.
- raddr_size[ADIM], raddr_stride[ADIM]  in  AW each  read dimension sizes and strides.
- wreq_num, waddr_base  in  AW  write count and write base address.
- waddr_size[ADIM], waddr_stride[ADIM]  in  AW each  write dimension sizes and strides.
- packed_dim_size (P), unpacked_dim_size (U)  in  AW  tile geometry.
- raddr, raddr_vld  out  AW, 1  read request.
- rdata, rdata_vld  in  BUFFD*8, 1  read return.
- waddr, wdata, wdata_vld  out  AW, BUFFD*8, 1  write.
- finish  out  1  done pulse.

Function
REQ-003 All outputs SHALL be registered.
REQ-004 init_pulse SHALL capture every configuration input. Configuration SHALL be ignored at all other times.
REQ-005 init_pulse SHALL clear both address generators, clear both counters and enter BUSY. This applies even when already BUSY.
REQ-006 States SHALL be IDLE and BUSY.
- IDLE -> BUSY on init_pulse.
- BUSY -> IDLE when the write count reaches wreq_num.
REQ-007 Read generator: index vector idx[0..ADIM-1], idx[0] innermost.
- raddr = raddr_base + sum(idx[d]*raddr_stride[d]), truncated modulo 2^AW.
- idx[d] wraps to 0 after size[d]-1 and carries into idx[d+1].
- A size of 0 SHALL be treated as 1.
- The outermost dimension SHALL wrap freely.
REQ-008 raddr_vld SHALL be 1 for exactly rreq_num consecutive cycles, starting the cycle after init_pulse, with one address per cycle.
REQ-009 rdata SHALL be accepted on any cycle with rdata_vld=1, in request order, at any latency.
REQ-010 Each accepted rdata SHALL produce wdata/wdata_vld exactly one cycle later.
- waddr comes from an identical generator using the waddr_* fields.
- wdata_vld pulses SHALL stop after wreq_num writes; later rdata SHALL be dropped.
REQ-011 Transform by mode (byte k = rdata[8k+7:8k]):
- 00: out = rdata (bypass).
- 01: tile transpose; out byte j*U+i = in byte i*P+j, for i<U and j<P.
- 10: byte reverse; out byte k = in byte BUFFD-1-k.
- 11: treated as 00.
REQ-012 In mode 01, output bytes at index >= P*U SHALL be 0 if repack_en=1, else copied from the same input index.
REQ-013 If P=0, U=0 or P*U>BUFFD, mode 01 SHALL behave as bypass.
REQ-014 finish SHALL pulse for 1 cycle, in the cycle after the final write (wdata_vld of write number wreq_num).
REQ-015 wreq_num=0 SHALL give a finish pulse 1 cycle after init_pulse. rreq_num=0 SHALL issue no reads.
REQ-016 rdata_vld while IDLE SHALL be ignored.

Reset
REQ-017 While reset_n is high, the block SHALL be in IDLE.
- raddr, raddr_vld, waddr, wdata, wdata_vld and finish all SHALL be 0.
- Counters and indices SHALL be 0.
REQ-018 Reset asserted mid-operation SHALL abort immediately with no finish pulse. A new init_pulse is then required to start again.

Verification
REQ-019 Linear read: base 0x100, size {4,1,1,1,1,1}, stride {1,0,0,0,0,0}, rreq_num 4 -> raddr 0x100, 0x101, 0x102, 0x103 on consecutive cycles starting 1 cycle after init_pulse.
REQ-020 2-D wrap: size {2,3,...}, stride {4,16,...}, base 0, rreq_num 6 -> raddr 0, 4, 16, 20, 32, 36.
REQ-021 Mode 01, P=4, U=2, repack_en=1, rdata bytes 0..63 = 0..63 -> wdata bytes 0,4,1,5,2,6,3,7, then 56 zero bytes, one cycle after rdata_vld.
REQ-022 Mode 10, rdata byte k = k -> wdata byte 0 = 63 and byte 63 = 0. Write addresses follow the waddr_* pattern. finish pulses 1 cycle after write number wreq_num.
REQ-023 wreq_num=2 with 3 rdata beats -> exactly 2 wdata_vld pulses and finish once. Reset asserted mid-transfer -> all outputs 0 and no finish.
